// File: rtl/mux_array_pkg.sv
// Shared constants for the word-wide registered 2:1 mux array.
package mux_array_pkg;

    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/mux_array_mux2_bit.sv
// Single-bit combinational 2:1 mux; X on sel propagates via plain ?:.
module mux2_bit (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux_array.sv
// WIDTH-bit 2:1 mux array with one registered output stage.
module mux_array
    import mux_array_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] o
);

    logic [WIDTH-1:0] mux_y;
    logic [WIDTH-1:0] o_d;
    logic [WIDTH-1:0] o_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2_bit u_mux (
            .a   (a[i]),
            .b   (b[i]),
            .sel (sel),
            .y   (mux_y[i])
        );
    end

    // Reset wins over any data input at the same edge.
    always_comb begin
        o_d = mux_y;
        if (rst) begin
            o_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        o_q <= o_d;
    end

    assign o = o_q;

endmodule

// File: tb/tb_mux_array.sv
// Self-checking bench for mux_array at WIDTH 4, 1 and 16.
module tb_mux_array;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  a4, b4, o4;
    logic        s4;
    logic [0:0]  a1, b1, o1;
    logic        s1;
    logic [15:0] a16, b16, o16;
    logic        s16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_array #(.WIDTH(4)) u_w4 (
        .clk (clk), .rst (rst), .a (a4), .b (b4), .sel (s4), .o (o4)
    );
    mux_array #(.WIDTH(1)) u_w1 (
        .clk (clk), .rst (rst), .a (a1), .b (b1), .sel (s1), .o (o1)
    );
    mux_array #(.WIDTH(16)) u_w16 (
        .clk (clk), .rst (rst), .a (a16), .b (b16), .sel (s16), .o (o16)
    );

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic [3:0] b;
        logic       sel;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the word chosen by sel, or zero under reset.
    function automatic logic [15:0] ref_o(input logic r, input logic s,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
        if (r) return 16'h0;
        return s ? y : x;
    endfunction

    initial begin
        vecs[0]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h0, "rst_cyc1"};
        vecs[1]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h0, "rst_cyc2"};
        vecs[2]  = '{1'b0, 4'hF, 4'h0, 1'b0, 4'hF, "sel_a"};
        vecs[3]  = '{1'b0, 4'hF, 4'h0, 1'b1, 4'h0, "sel_b"};
        vecs[4]  = '{1'b0, 4'hF, 4'h0, 1'b0, 4'hF, "sel_a_back"};
        vecs[5]  = '{1'b0, 4'hA, 4'h5, 1'b0, 4'hA, "alt_a"};
        vecs[6]  = '{1'b0, 4'hA, 4'h5, 1'b1, 4'h5, "alt_b"};
        vecs[7]  = '{1'b0, 4'hF, 4'h0, 1'b0, 4'hF, "pre_rst"};
        vecs[8]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h0, "mid_rst"};
        vecs[9]  = '{1'b0, 4'hF, 4'h6, 1'b1, 4'h6, "post_rst"};
        vecs[10] = '{1'b1, 4'h3, 4'hC, 1'b1, 4'h0, "rst_over_b"};
        vecs[11] = '{1'b0, 4'h3, 4'hC, 1'b1, 4'hC, "rst_release"};

        a1 = '0; b1 = '0; s1 = 1'b0;
        a16 = '0; b16 = '0; s16 = 1'b0;

        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst;
            a4  = vecs[i].a;
            b4  = vecs[i].b;
            s4  = vecs[i].sel;
            @(posedge clk);
            #1;
            check(vecs[i].name, {12'h0, o4}, {12'h0, vecs[i].exp});
        end

        // Simultaneous change of a, b and sel in a single cycle.
        rst = 1'b0; a4 = 4'h9; b4 = 4'h2; s4 = 1'b1;
        @(posedge clk); #1;
        check("simul_1", {12'h0, o4}, 16'h0002);
        a4 = 4'h7; b4 = 4'h8; s4 = 1'b0;
        @(posedge clk); #1;
        check("simul_2", {12'h0, o4}, 16'h0007);

        for (int n = 0; n < 1000; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            a4  = 4'($urandom);  b4  = 4'($urandom);  s4  = 1'($urandom);
            a1  = 1'($urandom);  b1  = 1'($urandom);  s1  = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
            @(posedge clk);
            #1;
            check("rand_w4", {12'h0, o4},
                  ref_o(rst, s4, {12'h0, a4}, {12'h0, b4}) & 16'h000F);
            check("rand_w1", {15'h0, o1},
                  ref_o(rst, s1, {15'h0, a1}, {15'h0, b1}) & 16'h0001);
            check("rand_w16", o16, ref_o(rst, s16, a16, b16));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
